// File: rtl/nx_fifo_wr_arb.sv
// Packet-atomic round-robin write arbiter in front of a shared nx_fifo.
// One requester owns the FIFO write port for a whole packet. A new packet
// is only granted while the FIFO has enough free slots to make progress.
module nx_fifo_wr_arb #(
    parameter int N_REQ     = 4,
    parameter int WIDTH     = 83,
    parameter int SLOT_W    = 5,
    parameter int MIN_FREE  = 4,
    parameter int MAX_BEATS = 16
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic [N_REQ-1:0]       req_valid_i,
    input  logic [N_REQ-1:0]       req_last_i,
    input  logic [N_REQ*WIDTH-1:0] req_data_i,
    output logic [N_REQ-1:0]       req_ready_o,
    input  logic                   fifo_full_i,
    input  logic [SLOT_W-1:0]      fifo_free_slots_i,
    output logic                   fifo_wen_o,
    output logic [WIDTH-1:0]       fifo_wdata_o,
    output logic                   grant_vld_o,
    output logic [2:0]             grant_id_o,
    output logic                   pkt_done_o,
    output logic                   len_err_o
);

    localparam int ID_W  = 3;
    localparam int CNT_W = $clog2(MAX_BEATS + 1);

    typedef enum logic {
        IDLE = 1'b0,
        PKT  = 1'b1
    } state_e;

    state_e           state_q, state_d;
    logic [ID_W-1:0]  rr_ptr_q, rr_ptr_d;
    logic [ID_W-1:0]  grant_id_q, grant_id_d;
    logic [CNT_W-1:0] beat_cnt_q, beat_cnt_d;
    logic             grant_vld_q, grant_vld_d;
    logic             pkt_done_q, pkt_done_d;
    logic             len_err_q, len_err_d;

    logic [7:0]       validExt;
    logic [7:0]       lastExt;
    logic [7:0]       readyExt;
    logic [WIDTH-1:0] dataArr [8];
    logic [ID_W:0]    candIdx;
    logic             winnerFound;
    logic [ID_W-1:0]  winnerIdx;
    logic             freeOk;
    logic             beatAccept;
    logic             lastBeat;
    logic             overLen;
    logic             pktClose;

    // Widen per-requester vectors to 8 entries so the 3-bit grant index selects exactly
    assign validExt = 8'(req_valid_i);
    assign lastExt  = 8'(req_last_i);

    // Split the flat data bus into one word per requester
    always_comb begin
        for (int i = 0; i < 8; i++) begin
            dataArr[i] = '0;
        end
        for (int i = 0; i < N_REQ; i++) begin
            dataArr[i] = req_data_i[i*WIDTH +: WIDTH];
        end
    end

    // Round-robin search for the first valid requester starting at rr_ptr
    always_comb begin
        winnerFound = 1'b0;
        winnerIdx   = '0;
        candIdx     = '0;
        for (int k = 0; k < N_REQ; k++) begin
            candIdx = {1'b0, rr_ptr_q} + (ID_W+1)'(k);
            if (candIdx >= (ID_W+1)'(N_REQ)) begin
                candIdx = candIdx - (ID_W+1)'(N_REQ);
            end
            if (!winnerFound && validExt[candIdx[ID_W-1:0]]) begin
                winnerFound = 1'b1;
                winnerIdx   = candIdx[ID_W-1:0];
            end
        end
    end

    assign freeOk     = (fifo_free_slots_i >= SLOT_W'(MIN_FREE));
    assign beatAccept = (state_q == PKT) && validExt[grant_id_q] && !fifo_full_i;
    assign lastBeat   = lastExt[grant_id_q];
    assign overLen    = (beat_cnt_q == CNT_W'(MAX_BEATS - 1)) && !lastBeat;
    assign pktClose   = beatAccept && (lastBeat || overLen);

    // State and grant registers, all returning to idle on reset
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            rr_ptr_q    <= '0;
            grant_id_q  <= '0;
            beat_cnt_q  <= '0;
            grant_vld_q <= 1'b0;
            pkt_done_q  <= 1'b0;
            len_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            grant_id_q  <= grant_id_d;
            beat_cnt_q  <= beat_cnt_d;
            grant_vld_q <= grant_vld_d;
            pkt_done_q  <= pkt_done_d;
            len_err_q   <= len_err_d;
        end
    end

    // Grant a new packet from IDLE, count beats and close the packet on last or overlength
    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        grant_id_d  = grant_id_q;
        beat_cnt_d  = beat_cnt_q;
        grant_vld_d = grant_vld_q;
        pkt_done_d  = 1'b0;
        len_err_d   = len_err_q;
        case (state_q)
            IDLE: begin
                if (winnerFound && freeOk) begin
                    state_d     = PKT;
                    grant_vld_d = 1'b1;
                    grant_id_d  = winnerIdx;
                end
            end
            PKT: begin
                if (beatAccept) begin
                    beat_cnt_d = beat_cnt_q + 1'b1;
                    if (overLen) begin
                        len_err_d = 1'b1;
                    end
                    if (pktClose) begin
                        state_d     = IDLE;
                        grant_vld_d = 1'b0;
                        beat_cnt_d  = '0;
                        pkt_done_d  = 1'b1;
                        rr_ptr_d    = (grant_id_q == ID_W'(N_REQ - 1)) ? '0 : grant_id_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Steer the granted requester onto the FIFO write port, stalling while full
    always_comb begin
        readyExt     = '0;
        fifo_wen_o   = 1'b0;
        fifo_wdata_o = '0;
        if (state_q == PKT) begin
            readyExt[grant_id_q] = !fifo_full_i;
            fifo_wen_o           = beatAccept;
        end
        if (grant_vld_q) begin
            fifo_wdata_o = dataArr[grant_id_q];
        end
    end

    assign req_ready_o = readyExt[N_REQ-1:0];
    assign grant_vld_o = grant_vld_q;
    assign grant_id_o  = grant_id_q;
    assign pkt_done_o  = pkt_done_q;
    assign len_err_o   = len_err_q;

endmodule

// File: tb/tb_nx_fifo_wr_arb.sv
// Table-driven bench for nx_fifo_wr_arb with 4 requesters and default sizes.
// Each table row gives one cycle of inputs and the outputs expected during it.
module tb_nx_fifo_wr_arb;

    localparam int N_REQ = 4;
    localparam int WIDTH = 83;
    localparam int SLOT_W = 5;

    typedef struct {
        logic        rst;
        logic [3:0]  valid;
        logic [3:0]  last;
        logic        full;
        logic [4:0]  free;
        logic [7:0]  tag;
        logic [3:0]  expReady;
        logic        expWen;
        logic        expGvld;
        logic [2:0]  expGid;
        logic        expDone;
        logic        expLenErr;
    } vec_t;

    logic                   clk;
    logic                   rst_n;
    logic [N_REQ-1:0]       reqValid;
    logic [N_REQ-1:0]       reqLast;
    logic [N_REQ*WIDTH-1:0] reqData;
    logic [N_REQ-1:0]       reqReady;
    logic                   fifoFull;
    logic [SLOT_W-1:0]      freeSlots;
    logic                   fifoWen;
    logic [WIDTH-1:0]       fifoWdata;
    logic                   grantVld;
    logic [2:0]             grantId;
    logic                   pktDone;
    logic                   lenErr;

    int   passCnt;
    int   totalCnt;
    vec_t vecs[$];

    nx_fifo_wr_arb #(
        .N_REQ(N_REQ), .WIDTH(WIDTH), .SLOT_W(SLOT_W), .MIN_FREE(4), .MAX_BEATS(16)
    ) dut (
        .clk_i(clk),
        .rst_ni(rst_n),
        .req_valid_i(reqValid),
        .req_last_i(reqLast),
        .req_data_i(reqData),
        .req_ready_o(reqReady),
        .fifo_full_i(fifoFull),
        .fifo_free_slots_i(freeSlots),
        .fifo_wen_o(fifoWen),
        .fifo_wdata_o(fifoWdata),
        .grant_vld_o(grantVld),
        .grant_id_o(grantId),
        .pkt_done_o(pktDone),
        .len_err_o(lenErr)
    );

    // Free-running clock, 10 time units per cycle
    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [WIDTH-1:0] mkData(input logic [7:0] tag, input logic [2:0] id);
        return {8'hA5, tag, 64'h0123_4567_89AB_CDEF, id};
    endfunction

    task automatic addRow(input logic rst, input logic [3:0] valid, input logic [3:0] last,
                          input logic full, input logic [4:0] free, input logic [7:0] tag,
                          input logic [3:0] expReady, input logic expWen, input logic expGvld,
                          input logic [2:0] expGid, input logic expDone, input logic expLenErr);
        vec_t v;
        v.rst = rst; v.valid = valid; v.last = last; v.full = full; v.free = free; v.tag = tag;
        v.expReady = expReady; v.expWen = expWen; v.expGvld = expGvld; v.expGid = expGid;
        v.expDone = expDone; v.expLenErr = expLenErr;
        vecs.push_back(v);
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [3:0] valid, input logic [3:0] last,
                                 input logic full, input logic [4:0] free, input logic [7:0] tag);
        reqValid  = valid;
        reqLast   = last;
        fifoFull  = full;
        freeSlots = free;
        for (int i = 0; i < N_REQ; i++) begin
            reqData[i*WIDTH +: WIDTH] = mkData(tag, 3'(i));
        end
    endtask

    task automatic checkOutput(input string name, input int row, input logic [127:0] act,
                               input logic [127:0] exp);
        totalCnt++;
        if (act === exp) begin
            passCnt++;
        end else begin
            $display("[TB] FAIL %s row %0d: got %0h, expected %0h", name, row, act, exp);
        end
    endtask

    task automatic checkAllZero(input string name, input int row);
        checkOutput({name, "_gvld"}, row, 128'(grantVld), 128'd0);
        checkOutput({name, "_gid"}, row, 128'(grantId), 128'd0);
        checkOutput({name, "_ready"}, row, 128'(reqReady), 128'd0);
        checkOutput({name, "_wen"}, row, 128'(fifoWen), 128'd0);
        checkOutput({name, "_wdata"}, row, 128'(fifoWdata), 128'd0);
        checkOutput({name, "_done"}, row, 128'(pktDone), 128'd0);
        checkOutput({name, "_lenerr"}, row, 128'(lenErr), 128'd0);
    endtask

    task automatic doReset(input int row);
        rst_n = 1'b0;
        applyStimulus(4'b0000, 4'b0000, 1'b0, 5'd25, 8'h00);
        #1;
        checkAllZero("rst", row);
        nextCycle();
        nextCycle();
        rst_n = 1'b1;
    endtask

    task automatic buildTable();
        logic [3:0] oneHot;
        // Single 3-beat packet from requester 0
        addRow(0, 4'b0001, 4'b0000, 0, 25, 8'h10, 4'b0000, 0, 0, 0, 0, 0);
        addRow(0, 4'b0001, 4'b0000, 0, 25, 8'h11, 4'b0001, 1, 1, 0, 0, 0);
        addRow(0, 4'b0001, 4'b0000, 0, 25, 8'h12, 4'b0001, 1, 1, 0, 0, 0);
        addRow(0, 4'b0001, 4'b0001, 0, 25, 8'h13, 4'b0001, 1, 1, 0, 0, 0);
        addRow(0, 4'b0000, 4'b0000, 0, 25, 8'h14, 4'b0000, 0, 0, 0, 1, 0);
        addRow(0, 4'b0000, 4'b0000, 0, 25, 8'h15, 4'b0000, 0, 0, 0, 0, 0);
        // All four requesters streaming 2-beat packets, round-robin 0,1,2,3,0
        for (int p = 0; p < 5; p++) begin
            oneHot = 4'b0001 << (p % 4);
            addRow(p == 0, 4'b1111, 4'b0000, 0, 25, 8'(8'h20 + 3*p), 4'b0000, 0, 0, 0, p > 0, 0);
            addRow(0, 4'b1111, 4'b0000, 0, 25, 8'(8'h21 + 3*p), oneHot, 1, 1, 3'(p % 4), 0, 0);
            addRow(0, 4'b1111, oneHot, 0, 25, 8'(8'h22 + 3*p), oneHot, 1, 1, 3'(p % 4), 0, 0);
        end
        addRow(0, 4'b0000, 4'b0000, 0, 25, 8'h40, 4'b0000, 0, 0, 0, 1, 0);
        // Requester 1 stalled by 5 full cycles, then drops valid for one beat
        addRow(0, 4'b0010, 4'b0000, 0, 25, 8'h41, 4'b0000, 0, 0, 0, 0, 0);
        addRow(0, 4'b1010, 4'b0000, 0, 25, 8'h42, 4'b0010, 1, 1, 1, 0, 0);
        for (int c = 0; c < 5; c++) begin
            addRow(0, 4'b1010, 4'b0000, 1, 25, 8'(8'h43 + c), 4'b0000, 0, 1, 1, 0, 0);
        end
        addRow(0, 4'b1010, 4'b0000, 0, 25, 8'h48, 4'b0010, 1, 1, 1, 0, 0);
        addRow(0, 4'b1000, 4'b0000, 0, 25, 8'h49, 4'b0010, 0, 1, 1, 0, 0);
        addRow(0, 4'b1010, 4'b0010, 0, 25, 8'h4A, 4'b0010, 1, 1, 1, 0, 0);
        addRow(0, 4'b0000, 4'b0000, 0, 25, 8'h4B, 4'b0000, 0, 0, 0, 1, 0);
        // Free-slot threshold: 3 blocks the grant, 4 allows it
        addRow(0, 4'b0100, 4'b0000, 0, 3, 8'h50, 4'b0000, 0, 0, 0, 0, 0);
        addRow(0, 4'b0100, 4'b0000, 0, 3, 8'h51, 4'b0000, 0, 0, 0, 0, 0);
        addRow(0, 4'b0100, 4'b0000, 0, 4, 8'h52, 4'b0000, 0, 0, 0, 0, 0);
        addRow(0, 4'b0100, 4'b0100, 0, 4, 8'h53, 4'b0100, 1, 1, 2, 0, 0);
        addRow(0, 4'b0000, 4'b0000, 0, 25, 8'h54, 4'b0000, 0, 0, 0, 1, 0);
        // Exactly MAX_BEATS beats with last on the final beat: no length error
        addRow(0, 4'b0001, 4'b0000, 0, 25, 8'h60, 4'b0000, 0, 0, 0, 0, 0);
        for (int b = 1; b <= 16; b++) begin
            addRow(0, 4'b0001, (b == 16) ? 4'b0001 : 4'b0000, 0, 25, 8'(8'h60 + b),
                   4'b0001, 1, 1, 0, 0, 0);
        end
        addRow(0, 4'b0000, 4'b0000, 0, 25, 8'h71, 4'b0000, 0, 0, 0, 1, 0);
        // Requester 3 sends 17 beats without last: forced close after 16, beat 17 re-granted
        addRow(0, 4'b1000, 4'b0000, 0, 25, 8'h80, 4'b0000, 0, 0, 0, 0, 0);
        for (int b = 1; b <= 16; b++) begin
            addRow(0, 4'b1000, 4'b0000, 0, 25, 8'(8'h80 + b), 4'b1000, 1, 1, 3, 0, 0);
        end
        addRow(0, 4'b1000, 4'b1000, 0, 25, 8'h91, 4'b0000, 0, 0, 0, 1, 1);
        addRow(0, 4'b1000, 4'b1000, 0, 25, 8'h92, 4'b1000, 1, 1, 3, 0, 1);
        addRow(0, 4'b0000, 4'b0000, 0, 25, 8'h93, 4'b0000, 0, 0, 0, 1, 1);
        addRow(0, 4'b0000, 4'b0000, 0, 25, 8'h94, 4'b0000, 0, 0, 0, 0, 1);
    endtask

    // Main sequence: reset, table rows, then the mid-packet reset corner case
    initial begin
        vec_t v;
        logic [WIDTH-1:0] expWdata;
        passCnt  = 0;
        totalCnt = 0;
        rst_n    = 1'b1;
        applyStimulus(4'b0000, 4'b0000, 1'b0, 5'd25, 8'h00);
        buildTable();
        #2;
        doReset(-1);

        for (int r = 0; r < vecs.size(); r++) begin
            v = vecs[r];
            if (v.rst) begin
                doReset(r);
            end
            applyStimulus(v.valid, v.last, v.full, v.free, v.tag);
            #3;
            expWdata = v.expGvld ? mkData(v.tag, v.expGid) : '0;
            checkOutput("ready", r, 128'(reqReady), 128'(v.expReady));
            checkOutput("wen", r, 128'(fifoWen), 128'(v.expWen));
            checkOutput("wdata", r, 128'(fifoWdata), 128'(expWdata));
            checkOutput("gvld", r, 128'(grantVld), 128'(v.expGvld));
            if (v.expGvld) begin
                checkOutput("gid", r, 128'(grantId), 128'(v.expGid));
            end
            checkOutput("done", r, 128'(pktDone), 128'(v.expDone));
            checkOutput("lenerr", r, 128'(lenErr), 128'(v.expLenErr));
            nextCycle();
        end

        // Reset asserted during beat 2 of a requester-0 packet
        applyStimulus(4'b0001, 4'b0000, 1'b0, 5'd25, 8'hC0);
        #3;
        checkOutput("s6_idle_gvld", 0, 128'(grantVld), 128'd0);
        nextCycle();
        applyStimulus(4'b0001, 4'b0000, 1'b0, 5'd25, 8'hC1);
        #3;
        checkOutput("s6_beat1_wen", 1, 128'(fifoWen), 128'd1);
        checkOutput("s6_beat1_gid", 1, 128'(grantId), 128'd0);
        nextCycle();
        applyStimulus(4'b0001, 4'b0000, 1'b0, 5'd25, 8'hC2);
        #1;
        checkOutput("s6_beat2_wen", 2, 128'(fifoWen), 128'd1);
        #1;
        rst_n = 1'b0;
        #1;
        checkAllZero("s6_async", 2);
        applyStimulus(4'b1010, 4'b0000, 1'b0, 5'd25, 8'hC3);
        nextCycle();
        rst_n = 1'b1;
        #3;
        checkOutput("s6_post_gvld", 3, 128'(grantVld), 128'd0);
        checkOutput("s6_post_ready", 3, 128'(reqReady), 128'd0);
        nextCycle();
        #3;
        checkOutput("s6_grant_gvld", 4, 128'(grantVld), 128'd1);
        checkOutput("s6_grant_gid", 4, 128'(grantId), 128'd1);
        checkOutput("s6_grant_ready", 4, 128'(reqReady), 128'b0010);
        checkOutput("s6_grant_wen", 4, 128'(fifoWen), 128'd1);
        checkOutput("s6_grant_wdata", 4, 128'(fifoWdata), 128'(mkData(8'hC3, 3'd1)));

        $display("%0d/%0d checks passed", passCnt, totalCnt);
        $finish;
    end

endmodule
